ps2_rx: RTL
===========

# ps2_rx

Host-side PS/2 receiver for the Basys3 USB-HID bridge: it receives the 11-bit device-to-host frames that the keyboard transmits on `PS2Clk`/`PS2Data`.
- Synchronizes and deglitches both lines.
- Shifts in each frame, checks start, parity and stop bits.
- Presents each good scan-code byte on a valid/ready handshake.

It sits beside the UART peripheral and is wrapped later as a memory-mapped peripheral on the SoC crossbar.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive core-clock cycles a synchronized line must hold a new level before the filtered copy follows.
- `TIMEOUT_CYCLES`, 80000: maximum core-clock cycles between falling edges inside a frame (2 ms at 40 MHz).

Ports:
- `clk` in 1: core clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `data` out 8: received byte, LSB = first data bit.
- `valid` out 1: `data` holds an unconsumed byte.
- `ready` in 1: consumer accepts `data` when `valid & ready`.
- `overrun` out 1: sticky flag; a good frame was dropped because `valid` was still high.
- `parity_err` out 1: one-cycle pulse on a parity failure.
- `frame_err` out 1: one-cycle pulse on a stop-bit failure or a timeout.

## Operation
Input conditioning:
- Each pin passes through a 2-FF synchronizer, then a `FILTER_LEN` stability filter. Both lines use an identical delay so they stay aligned.
- Falling edge `fe` = previous filtered clock high and current filtered clock low.
- Data is sampled on `fe` only.

State machine:
- **IDLE**
  - On `fe` with data 0, go to DATA and clear the bit counter and shifter.
  - On `fe` with data 1, ignore the edge.
- **DATA**
  - On each `fe`, shift the data bit in at MSB and shift right; increment the 3-bit counter.
  - After the 8th bit, go to PARITY.
- **PARITY**
  - On `fe`, store the bit. Parity is good when XOR of the 8 data bits and the parity bit = 1 (odd parity).
  - Go to STOP.
- **STOP**, on `fe`:
  - Stop bit = 0: pulse `frame_err`, discard.
  - Else parity bad: pulse `parity_err`, discard.
  - Else if `valid` is high and `ready` is low: set `overrun`, discard the byte, keep the old `data`.
  - Else load `data` and set `valid`.
  - Always return to IDLE.

Handshake:
- `valid` stays high until the cycle `valid & ready`, then falls next cycle.
- `data` is stable while `valid` is high.
- A completed handshake clears `overrun`.
- Same-cycle accept and new byte: the handshake consumes the old byte, the new byte loads, and `valid` stays high with no overrun.

Reset:
- Reset mid-frame returns to IDLE, drops the partial frame, and restarts the filters.
- After reset, the filtered lines equal 1, so no spurious `fe` occurs.
- Reset values: `data`=0, `valid`=0, `overrun`=0, `parity_err`=0, `frame_err`=0.

## Timing
- Pin fall to `fe`: 2 (sync) + `FILTER_LEN` cycles. `fe` is registered into state/shifter on that cycle's clock edge.
- `valid` rises `FILTER_LEN`+3 cycles after the raw stop-bit falling edge of `ps2_clk`.
- Error pulses have the same latency and last exactly 1 cycle.
- Pulses narrower than `FILTER_LEN` cycles on either pin are suppressed entirely.
- The filter counter saturates and restarts on any level mismatch.
- Timeout counter:
  - Width = ceil(log2(`TIMEOUT_CYCLES`+1)).
  - Clears on every `fe` and in IDLE; counts in DATA, PARITY and STOP.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_err` and go to IDLE on the next cycle.
  - If `fe` and timeout occur in the same cycle, `fe` wins.

## Configuration
- `PS2_RX_TIMEOUT_EN`:
  - Defined: timeout counter present, behaviour as above.
  - Undefined: no counter; `TIMEOUT_CYCLES` is unused and a stalled frame waits indefinitely for further edges.
- All other behaviour is identical in both builds.

## Structure
- Package `ps2_pkg`:
  - State enum (`PS2_IDLE`, `PS2_DATA`, `PS2_PARITY`, `PS2_STOP`).
  - `PS2_DATA_BITS` = 8.
  - `PS2_FRAME_BITS` = 11.
- Sub-module `ps2_filter`:
  - Synchronizer plus stability counter, parameter `FILTER_LEN`.
  - Instantiated twice, once per pin.
- Top `ps2_rx` holds edge detection, the FSM, the shifter, the timeout and the output register.

## Test plan
- **Good frame:** send scan code 0x1C (start 0, bits 00111000 LSB-first, parity 0, stop 1) at a 12.5 kHz PS/2 clock, `ready`=1 → `valid` 1-cycle pulse with `data`=0x1C, no error pulses.
- **Parity error:** send 0x1C with parity bit 1 → single `parity_err` pulse, `valid` stays 0.
- **Stop-bit error:** send 0xF0 with stop bit 0 → single `frame_err` pulse, `valid` stays 0.
- **Overrun:** send 0x1C then 0x32 with `ready`=0 → `data`=0x1C held, `overrun`=1. Then assert `ready` for 1 cycle → `valid` falls and `overrun` clears.
- **Glitch rejection:** a 3-cycle low glitch on `ps2_clk` in IDLE, plus a 5-cycle glitch inside a frame, with `FILTER_LEN`=8 → no state change, frame still decodes correctly.
- **Timeout and reset:** stop the PS/2 clock after 4 data bits.
  - Timeout build: `frame_err` pulses `TIMEOUT_CYCLES` cycles after the last `fe`, the FSM is in IDLE, and a following good 0x5A frame decodes.
  - Both builds: asserting `rst` mid-frame sets all outputs to 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Purpose : shared types and constants for the PS/2 receive path.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;   // start + 8 data + parity + stop

   typedef enum logic [1:0] {
      PS2_IDLE   = 2'd0,
      PS2_DATA   = 2'd1,
      PS2_PARITY = 2'd2,
      PS2_STOP   = 2'd3
   } ps2_state_t;

endpackage

// File: rtl/ps2_filter.sv
// Purpose : 2-FF synchronizer plus stability filter for one raw PS/2 pin.
// Latency : a level change reaches 'level' 2 + FILTER_LEN cycles after the pin moves.
// Backpressure: none; free-running conditioner.
//
// Ports: clk/rst (sync, active-high), pin (raw async input),
//        level (filtered copy, resets to 1 = idle bus level).
module ps2_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level
);

   localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] cnt;

   // The counter tracks how long the synchronized pin has disagreed with
   // 'level'. Any agreement restarts it, so only a run of FILTER_LEN
   // consecutive differing samples moves the filtered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
      end else begin
         sync_1 <= pin;
         sync_2 <= sync_1;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx.sv
// Purpose : host-side PS/2 device-to-host frame receiver with valid/ready byte output.
// Latency : valid / error pulses appear FILTER_LEN+3 cycles after the raw stop-bit clock fall.
// Backpressure: one-byte holding register; a good frame arriving while it is full is
//               dropped and flags sticky 'overrun' (a same-cycle accept makes room).
//
// Ports: clk, rst (sync, active-high); ps2_clk/ps2_data (raw pins);
//        data/valid/ready (byte handshake); overrun (sticky), parity_err and
//        frame_err (1-cycle pulses).
// Build option: define PS2_RX_TIMEOUT_EN to abort frames whose clock stalls for
//               TIMEOUT_CYCLES; otherwise a stalled frame waits indefinitely.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 80000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       overrun,
   output logic       parity_err,
   output logic       frame_err
);

   logic ps2_clk_f;
   logic ps2_data_f;
   logic ps2_clk_fd;
   logic fe;

   // Identical filters keep clock and data aligned, so data sampled on the
   // filtered clock fall is the bit the device presented at the raw fall.
   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (ps2_clk),
      .level (ps2_clk_f)
   );

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (ps2_data),
      .level (ps2_data_f)
   );

   always_ff @(posedge clk) begin
      if (rst) ps2_clk_fd <= 1'b1;
      else     ps2_clk_fd <= ps2_clk_f;
   end

   assign fe = ps2_clk_fd & ~ps2_clk_f;

   ps2_state_t               state;
   logic [2:0]               bit_cnt;
   logic [PS2_DATA_BITS-1:0] shifter;
   logic                     par_bit;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_FIRE = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;
   logic          timeout;

   // Cycles since the last falling edge while a frame is open. The abort is
   // registered on the edge that brings the count to TIMEOUT_CYCLES.
   always_ff @(posedge clk) begin
      if (rst || state == PS2_IDLE || fe) to_cnt <= '0;
      else if (to_cnt != TO_MAX)          to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state != PS2_IDLE) && (to_cnt == TO_FIRE);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PS2_IDLE;
         bit_cnt    <= '0;
         shifter    <= '0;
         par_bit    <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;

         // Consumer handshake; a byte loaded below in the same cycle
         // overrides the valid clear.
         if (valid && ready) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end

         if (fe) begin
            case (state)
               PS2_IDLE: begin
                  if (!ps2_data_f) begin
                     state   <= PS2_DATA;
                     bit_cnt <= '0;
                     shifter <= '0;
                  end
               end
               PS2_DATA: begin
                  // LSB arrives first: insert at MSB, shift toward bit 0.
                  shifter <= {ps2_data_f, shifter[PS2_DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state <= PS2_PARITY;
               end
               PS2_PARITY: begin
                  par_bit <= ps2_data_f;
                  state   <= PS2_STOP;
               end
               PS2_STOP: begin
                  state <= PS2_IDLE;
                  if (!ps2_data_f) begin
                     frame_err <= 1'b1;
                  end else if (!(^{shifter, par_bit})) begin
                     parity_err <= 1'b1;
                  end else if (valid && !ready) begin
                     overrun <= 1'b1;
                  end else begin
                     data  <= shifter;
                     valid <= 1'b1;
                  end
               end
               default: state <= PS2_IDLE;
            endcase
         end
`ifdef PS2_RX_TIMEOUT_EN
         else if (timeout) begin
            state     <= PS2_IDLE;
            frame_err <= 1'b1;
         end
`endif
      end
   end

endmodule
